// File: rtl/esop_cube_stream_eval.sv
// esop_cube_stream_eval
// Sequential XOR-of-cubes evaluator. One input vector is latched on start,
// then a stream of cubes (care/polarity masks) is consumed one per cycle over
// a valid/ready handshake. Each cube's AND-term is XOR-accumulated into a parity
// result. The result is published together with a one-cycle done pulse.
//
// Optional feature macro: ESOP_HIT_CNT_EN
//   defined   -> adds output hit_count, the number of cubes that hit in the
//                current/last evaluation (saturating)
//   undefined -> port and logic absent
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; cubes are not consumed
// EVAL  | accepting cubes, accumulating parity, counting cubes
// DONE  | single cycle: done pulse, result valid; returns to IDLE
module esop_cube_stream_eval #(
  parameter int NUM_VARS  = 50,
  parameter int MAX_CUBES = 64,
  parameter int CNT_W     = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_VARS-1:0] x,
  input  logic                cube_valid,
  output logic                cube_ready,
  input  logic [NUM_VARS-1:0] cube_care,
  input  logic [NUM_VARS-1:0] cube_pol,
  input  logic                cube_last,
  output logic                busy,
  output logic                done,
  output logic                result,
  output logic [CNT_W-1:0]    cube_count,
`ifdef ESOP_HIT_CNT_EN
  output logic [CNT_W-1:0]    hit_count,
`endif
  output logic                overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CUBES);

  state_t              state, state_nxt;
  logic [NUM_VARS-1:0] x_reg;
  logic                acc;
  logic                hit;
  logic                handshake;
  logic                start_acc;

  // Cube term: every cared-for variable must match its polarity; care=0 always hits.
  assign hit = (((x_reg ^ cube_pol) & cube_care) == '0);

  assign handshake = cube_valid && cube_ready;
  assign start_acc = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    cube_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = EVAL;
      end
      EVAL: begin
        cube_ready = 1'b1;
        busy       = 1'b1;
        if (cube_valid && cube_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch vector, accumulate parity, count cubes, flag overflow.
  // The result is written at the last handshake so that it is already valid
  // in the DONE cycle, which is the cycle after that handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg      <= '0;
      acc        <= 1'b0;
      result     <= 1'b0;
      cube_count <= '0;
      overflow   <= 1'b0;
    end else if (start_acc) begin
      x_reg      <= x;
      acc        <= 1'b0;
      cube_count <= '0;
      overflow   <= 1'b0;
    end else if (handshake) begin
      acc <= acc ^ hit;
      if (cube_last) result <= acc ^ hit;
      if (cube_count != CNT_SAT) cube_count <= cube_count + 1'b1;
      if (cube_count == CNT_LIMIT) overflow <= 1'b1;
    end
  end

`ifdef ESOP_HIT_CNT_EN
  // Saturating count of cubes that hit in the current evaluation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (start_acc) begin
      hit_count <= '0;
    end else if (handshake && hit && (hit_count != CNT_SAT)) begin
      hit_count <= hit_count + 1'b1;
    end
  end
`endif

endmodule
